// File: rtl/hack_cpu_ctrl_if.sv
// Instruction-fetch and data-memory req/ack bus between the Hack CPU core and its ROM/RAM agents.
interface hack_cpu_ctrl_if;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic        instr_ack;
    logic [15:0] instr_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  instr_ack, instr_data, mem_ack, mem_rdata
    );

    modport slave (
        input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output instr_ack, instr_data, mem_ack, mem_rdata
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetch, decode, optional M read, ALU execute, optional M write.
// All bus outputs are decoded from registered state so no ack ever reaches a req combinationally.
module hack_cpu_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    hack_cpu_ctrl_if.master        bus,
    output logic [15:0]            pc_out,
    output logic [15:0]            a_out,
    output logic [15:0]            d_out,
    output logic                   retire
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEMRD  = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEMWR  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] m_q, m_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        retire_q, retire_d;

    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        jmp_taken;

    // ctl = {zx, nx, zy, ny, f, no}
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] ctl);
        logic [15:0] xs;
        logic [15:0] ys;
        logic [15:0] r;
        xs = ctl[5] ? 16'h0000 : x;
        if (ctl[4]) xs = ~xs;
        ys = ctl[3] ? 16'h0000 : y;
        if (ctl[2]) ys = ~ys;
        r = ctl[1] ? (xs + ys) : (xs & ys);
        if (ctl[0]) r = ~r;
        return r;
    endfunction

    always_comb begin
        alu_y     = ir_q[12] ? m_q : a_q;
        alu_out   = hack_alu(d_q, alu_y, ir_q[11:6]);
        alu_zr    = (alu_out == 16'h0000);
        alu_ng    = alu_out[15];
        jmp_taken = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        d_d         = d_q;
        ir_d        = ir_q;
        m_d         = m_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.instr_ack) begin
                    ir_d    = bus.instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_d      = ir_q;
                    pc_d     = pc_q + 16'd1;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else if (ir_q[12]) begin
                    mem_addr_d = a_q;
                    state_d    = S_MEMRD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ack) begin
                    m_d     = bus.mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Jump target and M address take A as it was before this cycle's update.
                pc_d = jmp_taken ? a_q : (pc_q + 16'd1);
                if (ir_q[5]) a_d = alu_out;
                if (ir_q[4]) d_d = alu_out;
                if (ir_q[3]) begin
                    mem_addr_d  = a_q;
                    mem_wdata_d = alu_out;
                    state_d     = S_MEMWR;
                end else begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ack) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            a_q         <= 16'h0000;
            d_q         <= 16'h0000;
            ir_q        <= 16'h0000;
            m_q         <= 16'h0000;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            d_q         <= d_d;
            ir_q        <= ir_d;
            m_q         <= m_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
        end
    end

    assign bus.instr_req  = (state_q == S_FETCH);
    assign bus.instr_addr = pc_q;
    assign bus.mem_req    = (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign bus.mem_we     = (state_q == S_MEMWR);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign pc_out         = pc_q;
    assign a_out          = a_q;
    assign d_out          = d_q;
    assign retire         = retire_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: the initial block acts as ROM/RAM agent with hand-computed results.
module tb_hack_cpu_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_out, a_out, d_out;
    logic        retire;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int ret_cnt = 0;
    int mem_cyc = 0;
    int overlap = 0;
    int r0;
    int m0;
    int t;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .pc_out (pc_out),
        .a_out  (a_out),
        .d_out  (d_out),
        .retire (retire)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (retire) ret_cnt++;
        if (bus.mem_req) mem_cyc++;
        if (bus.instr_req && bus.mem_req) overlap++;
    endtask

    task automatic fetch(input logic [15:0] instr, input logic [15:0] exp_addr, input int waits);
        int n;
        n = 0;
        while (!bus.instr_req && n < 20) begin step(); n++; end
        chk("fetch_req_timeout", {15'd0, bus.instr_req}, 16'h0001);
        chk("fetch_addr", bus.instr_addr, exp_addr);
        for (int w = 0; w < waits; w++) begin
            step();
            chk("fetch_hold_req", {15'd0, bus.instr_req}, 16'h0001);
            chk("fetch_hold_addr", bus.instr_addr, exp_addr);
        end
        bus.instr_ack  = 1'b1;
        bus.instr_data = instr;
        step();
        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'h0000;
        chk("fetch_req_drop", {15'd0, bus.instr_req}, 16'h0000);
    endtask

    task automatic mem_rd(input logic [15:0] exp_addr, input logic [15:0] rdata, input int waits);
        int n;
        n = 0;
        while (!bus.mem_req && n < 20) begin step(); n++; end
        chk("rd_req_timeout", {15'd0, bus.mem_req}, 16'h0001);
        chk("rd_we", {15'd0, bus.mem_we}, 16'h0000);
        chk("rd_addr", bus.mem_addr, exp_addr);
        for (int w = 0; w < waits; w++) begin
            step();
            chk("rd_hold_req", {14'd0, bus.mem_req, bus.mem_we}, 16'h0002);
            chk("rd_hold_addr", bus.mem_addr, exp_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic mem_wr(input logic [15:0] exp_addr, input logic [15:0] exp_data, input int waits);
        int n;
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 20) begin step(); n++; end
        chk("wr_req_timeout", {14'd0, bus.mem_req, bus.mem_we}, 16'h0003);
        chk("wr_addr", bus.mem_addr, exp_addr);
        chk("wr_data", bus.mem_wdata, exp_data);
        chk("wr_no_early_retire", {15'd0, retire}, 16'h0000);
        for (int w = 0; w < waits; w++) begin
            step();
            chk("wr_hold_req", {14'd0, bus.mem_req, bus.mem_we}, 16'h0003);
            chk("wr_hold_addr", bus.mem_addr, exp_addr);
            chk("wr_hold_data", bus.mem_wdata, exp_data);
        end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("wr_retire", {15'd0, retire}, 16'h0001);
    endtask

    // Fetch an instruction with no memory traffic and wait for its retire pulse.
    task automatic run(input logic [15:0] instr, input logic [15:0] exp_addr);
        int n;
        m0 = mem_cyc;
        fetch(instr, exp_addr, 0);
        n = 0;
        while (!retire && n < 20) begin step(); n++; end
        chk("run_retire_timeout", {15'd0, retire}, 16'h0001);
        chk("run_no_mem", 16'(mem_cyc - m0), 16'h0000);
    endtask

    initial begin
        reset          = 1'b1;
        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'h0000;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 16'h0000;
        step(); step(); step();
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_a", a_out, 16'h0000);
        chk("rst_d", d_out, 16'h0000);
        chk("rst_reqs", {13'd0, bus.instr_req, bus.mem_req, bus.mem_we}, 16'h0000);
        chk("rst_retire", {15'd0, retire}, 16'h0000);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);

        // Test 1: A-instruction @5
        reset = 1'b0;
        chk("boot_no_req", {15'd0, bus.instr_req}, 16'h0000);
        step();
        chk("boot_req_rise", {15'd0, bus.instr_req}, 16'h0001);
        r0 = ret_cnt;
        fetch(16'h0005, 16'h0000, 0);
        step();
        chk("t1_retire", {15'd0, retire}, 16'h0001);
        chk("t1_a", a_out, 16'h0005);
        chk("t1_pc", pc_out, 16'h0001);
        step(); step();
        chk("t1_retire_once", 16'(ret_cnt - r0), 16'h0001);

        // Test 2: D=A, three cycles from fetch ack to commit
        m0 = mem_cyc;
        fetch(16'hEC10, 16'h0001, 0);
        step();
        chk("t2_no_early_retire", {15'd0, retire}, 16'h0000);
        step();
        chk("t2_retire", {15'd0, retire}, 16'h0001);
        chk("t2_d", d_out, 16'h0005);
        chk("t2_pc", pc_out, 16'h0002);
        chk("t2_no_mem", 16'(mem_cyc - m0), 16'h0000);

        // Test 3: AM=M+1 with A=5, M[5]=9
        fetch(16'hFDE8, 16'h0002, 0);
        mem_rd(16'h0005, 16'h0009, 0);
        mem_wr(16'h0005, 16'h000A, 0);
        chk("t3_a", a_out, 16'h000A);
        chk("t3_pc", pc_out, 16'h0003);

        // Test 4: jumps and PC wrap
        run(16'h0000, 16'h0003);
        run(16'hEC10, 16'h0004);
        chk("t4_d_zero", d_out, 16'h0000);
        run(16'h0014, 16'h0005);
        chk("t4_a20", a_out, 16'h0014);
        run(16'hE302, 16'h0006);
        chk("t4_jeq_taken", pc_out, 16'h0014);
        run(16'hEE90, 16'h0014);
        chk("t4_d_m1", d_out, 16'hFFFF);
        run(16'hE301, 16'h0015);
        chk("t4_jgt_not_taken", pc_out, 16'h0016);
        run(16'hEEA0, 16'h0016);
        chk("t4_a_m1", a_out, 16'hFFFF);
        run(16'hEA87, 16'h0017);
        chk("t4_jmp_ffff", pc_out, 16'hFFFF);
        run(16'h0007, 16'hFFFF);
        chk("t4_pc_wrap", pc_out, 16'h0000);
        chk("t4_a7", a_out, 16'h0007);

        // Test 5: three-cycle waits on every handshake
        r0 = ret_cnt;
        fetch(16'hFDE8, 16'h0000, 3);
        mem_rd(16'h0007, 16'h0100, 3);
        mem_wr(16'h0007, 16'h0101, 3);
        chk("t5_a", a_out, 16'h0101);
        chk("t5_d_kept", d_out, 16'hFFFF);
        chk("t5_pc", pc_out, 16'h0001);
        step(); step();
        chk("t5_single_retire", 16'(ret_cnt - r0), 16'h0001);
        chk("t5_mem_idle", {15'd0, bus.mem_req}, 16'h0000);

        // Test 6: reset while waiting in MEMRD
        fetch(16'hFDE8, 16'h0001, 0);
        t = 0;
        while (!bus.mem_req && t < 20) begin step(); t++; end
        chk("t6_in_memrd", {14'd0, bus.mem_req, bus.mem_we}, 16'h0002);
        reset = 1'b1;
        step();
        chk("t6_mem_req_drop", {15'd0, bus.mem_req}, 16'h0000);
        chk("t6_pc", pc_out, 16'h0000);
        chk("t6_a", a_out, 16'h0000);
        chk("t6_d", d_out, 16'h0000);
        chk("t6_instr_req", {15'd0, bus.instr_req}, 16'h0000);
        reset = 1'b0;
        step();
        chk("t6_fetch_req", {15'd0, bus.instr_req}, 16'h0001);
        chk("t6_fetch_addr", bus.instr_addr, 16'h0000);

        chk("req_overlap", 16'(overlap), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
